// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan controller.
//   SEG_BLANK    : all segments off (active-low bus)
//   AN_OFF       : all digit enables off (active-low anodes)
//   scan_state_e : phase within a digit slot (dead-time or driving)
//   digit_idx_t  : index of the digit currently being scanned (3 = leftmost)
package seg_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DIGITS = 4;

    localparam logic [SEG_W-1:0]  SEG_BLANK = 7'h7F;
    localparam logic [DIGITS-1:0] AN_OFF    = 4'hF;

    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_DRIVE = 1'b1
    } scan_state_e;

    typedef logic [1:0] digit_idx_t;

    // Active-low one-cold anode pattern for a digit index.
    function automatic logic [DIGITS-1:0] an_select(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer for the 7-segment scanner.
// Counts cnt 0..SCAN_DIV-1 while enabled and steps the digit index 3->2->1->0->3
// on every wrap. Disable parks the timer at the frame start (idx=3, cnt=0).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   en_i           : scan enable; low clears the timer synchronously
//   idx_o          : digit currently owning the slot
//   in_blank_c     : slot is in its dead-time window (combinational decode)
//   frame_tick_c   : enabled and at the first cycle of a frame (combinational decode)
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    output digit_idx_t idx_o,
    output logic       in_blank_c,
    output logic       frame_tick_c
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;

    // Next-state: wrap the slot counter and rotate the digit index downward.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!en_i) begin
            cnt_d = '0;
            idx_d = 2'd3;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q - 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= 2'd3;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // A zero-length dead-time would make the comparison trivially false.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank_c = 1'b0;
        end else begin : g_blank
            assign in_blank_c = (cnt_q < CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    assign frame_tick_c = en_i && (idx_q == 2'd3) && (cnt_q == '0);
    assign idx_o        = idx_q;

endmodule

// File: rtl/seg_scan_controller.sv
// Four-digit 7-segment scan controller.
// Multiplexes four active-low digit codes onto a shared segment bus with
// active-low anodes. All four digits are snapshotted at the start of each
// frame so a frame never mixes old and new values; each slot begins with a
// dead-time of BLANK_CYCLES where all digits are dark to avoid ghosting.
// Optional blinking is compiled in with the SEG_BLINK_EN macro; without it
// the blink port is ignored and no frame counter exists.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : scan enable; low darkens the display and restarts the frame
//   blink               : blink request (SEG_BLINK_EN only)
//   digit3..digit0      : active-low segment codes, digit3 leftmost
//   seg                 : shared segment bus, active-low, registered
//   an                  : digit enables, active-low, registered
//   frame_start         : one-cycle pulse after each snapshot, registered
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             blink,
    input  logic [SEG_W-1:0] digit3,
    input  logic [SEG_W-1:0] digit2,
    input  logic [SEG_W-1:0] digit1,
    input  logic [SEG_W-1:0] digit0,
    output logic [SEG_W-1:0] seg,
    output logic [3:0]       an,
    output logic             frame_start
);

    logic [DIGITS-1:0][SEG_W-1:0] digit_in_c;
    logic [DIGITS-1:0][SEG_W-1:0] shadow_q, shadow_d;

    digit_idx_t  idx_c;
    logic        in_blank_c;
    logic        frame_tick_c;
    scan_state_e state_c;
    logic        dark_c;
    logic [SEG_W-1:0] cur_seg_c;

    logic [SEG_W-1:0] seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             fs_q, fs_d;

    assign digit_in_c = {digit3, digit2, digit1, digit0};

    seg_scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .idx_o        (idx_c),
        .in_blank_c   (in_blank_c),
        .frame_tick_c (frame_tick_c)
    );

    assign state_c = in_blank_c ? SCAN_BLANK : SCAN_DRIVE;

`ifdef SEG_BLINK_EN
    // Frame counter: after BLINK_FRAMES snapshots the phase flips.
    // Counting to BLINK_FRAMES (not BLINK_FRAMES-1) keeps the first
    // BLINK_FRAMES frames of a blink request visible.
    localparam int unsigned FRM_W = $clog2(BLINK_FRAMES + 1);

    logic [FRM_W-1:0] frm_q, frm_d;
    logic             phase_q, phase_d;

    always_comb begin
        frm_d   = frm_q;
        phase_d = phase_q;
        if (!en || !blink) begin
            frm_d   = '0;
            phase_d = 1'b0;
        end else if (frame_tick_c) begin
            if (frm_q == FRM_W'(BLINK_FRAMES)) begin
                frm_d   = FRM_W'(1);
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FRM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            frm_q   <= frm_d;
            phase_q <= phase_d;
        end
    end

    // Look-ahead phase so the first DRIVE cycle of a frame already obeys it.
    assign dark_c = phase_d;
`else
    logic unused_blink_c;
    assign unused_blink_c = blink & (BLINK_FRAMES != 0);
    assign dark_c         = 1'b0;
`endif

    // On the snapshot cycle the shadow regs still hold the previous frame,
    // so the live inputs are forwarded (matters only when BLANK_CYCLES=0).
    assign cur_seg_c = frame_tick_c ? digit_in_c[idx_c] : shadow_q[idx_c];

    assign shadow_d = frame_tick_c ? digit_in_c : shadow_q;

    // Output decode for the next cycle; default is fully dark.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        fs_d  = 1'b0;
        if (en) begin
            fs_d = frame_tick_c;
            if (state_c == SCAN_DRIVE) begin
                an_d  = an_select(idx_c);
                seg_d = dark_c ? SEG_BLANK : cur_seg_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= {DIGITS{SEG_BLANK}};
            an_q     <= AN_OFF;
            seg_q    <= SEG_BLANK;
            fs_q     <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            fs_q     <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
module tb_seg_scan_controller;

    localparam int unsigned SCAN_DIV     = 8;
    localparam int unsigned BLANK_CYCLES = 2;
    localparam int unsigned BLINK_FRAMES = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       blink;
    logic [6:0] digit3, digit2, digit1, digit0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_start;

    exp_t  sb[$];
    int    n_pass  = 0;
    int    n_total = 0;
    string cur_test = "reset";
    logic  dk;

    logic [3:0] last_drv = 4'hF;
    int         run_f    = 0;

    always #5 clk = ~clk;

    seg_scan_controller #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .blink       (blink),
        .digit3      (digit3),
        .digit2      (digit2),
        .digit1      (digit1),
        .digit0      (digit0),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    task automatic chk(input string nm, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp_v, $time);
    endtask

    // Expected outputs p cycles after a snapshot edge: 8-cycle slots, 2 dark
    // cycles each, digits in order 3,2,1,0.
    function automatic exp_t exp_at(input int p, input logic [6:0] d3, input logic [6:0] d2,
                                    input logic [6:0] d1, input logic [6:0] d0, input logic dark);
        exp_t e;
        int   slot;
        int   w;
        slot  = p / 8;
        w     = p % 8;
        e.fs  = (p == 0);
        e.an  = 4'hF;
        e.seg = 7'h7F;
        if (w >= 2) begin
            case (slot)
                0:       begin e.an = 4'h7; e.seg = d3; end
                1:       begin e.an = 4'hB; e.seg = d2; end
                2:       begin e.an = 4'hD; e.seg = d1; end
                default: begin e.an = 4'hE; e.seg = d0; end
            endcase
            if (dark) e.seg = 7'h7F;
        end
        return e;
    endfunction

    task automatic tick(input exp_t e);
        @(posedge clk);
        #1;
        sb.push_back(e);
    endtask

    task automatic run_frame(input logic [6:0] d3, input logic [6:0] d2, input logic [6:0] d1,
                             input logic [6:0] d0, input logic dark);
        for (int p = 0; p < 32; p++) tick(exp_at(p, d3, d2, d1, d0, dark));
    endtask

    // Scoreboard monitor: one expected entry per cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("%s_out", cur_test), int'({an, seg, frame_start}), int'(e));
        end
    end

    // Structural checks: at most one anode low, and a dead-time between distinct digits.
    always @(negedge clk) begin
        chk("an_onehot", int'($countones(~an) <= 1), 1);
        if (an == 4'hF) begin
            run_f++;
        end else begin
            if (last_drv != 4'hF && an != last_drv) chk("blank_gap", int'(run_f >= 2), 1);
            last_drv = an;
            run_f    = 0;
        end
    end

    initial begin
`ifdef SEG_BLINK_EN
        dk = 1'b1;
`else
        dk = 1'b0;
`endif
        rst_n  = 1'b0;
        en     = 1'b1;
        blink  = 1'b0;
        digit3 = 7'h40;
        digit2 = 7'h79;
        digit1 = 7'h24;
        digit0 = 7'h30;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_an", int'(an), 'hF);
        chk("rst_seg", int'(seg), 'h7F);
        chk("rst_fs", int'(frame_start), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic scan, then a mid-frame input change hidden until the next snapshot.
        cur_test = "t1";
        run_frame(7'h40, 7'h79, 7'h24, 7'h30, 1'b0);
        cur_test = "t2";
        for (int p = 0; p < 32; p++) begin
            tick(exp_at(p, 7'h40, 7'h79, 7'h24, 7'h30, 1'b0));
            if (p == 3) digit1 = 7'h19;
        end
        run_frame(7'h40, 7'h79, 7'h19, 7'h30, 1'b0);

        // Enable drop during digit2 DRIVE.
        cur_test = "t3";
        for (int p = 0; p < 12; p++) tick(exp_at(p, 7'h40, 7'h79, 7'h19, 7'h30, 1'b0));
        en = 1'b0;
        repeat (5) tick(exp_t'{4'hF, 7'h7F, 1'b0});
        en = 1'b1;
        run_frame(7'h40, 7'h79, 7'h19, 7'h30, 1'b0);

        // Blink: two visible frames, two dark, repeating; release mid-dark.
        cur_test = "t6";
        blink = 1'b1;
        run_frame(7'h40, 7'h79, 7'h19, 7'h30, 1'b0);
        run_frame(7'h40, 7'h79, 7'h19, 7'h30, 1'b0);
        run_frame(7'h40, 7'h79, 7'h19, 7'h30, dk);
        run_frame(7'h40, 7'h79, 7'h19, 7'h30, dk);
        run_frame(7'h40, 7'h79, 7'h19, 7'h30, 1'b0);
        run_frame(7'h40, 7'h79, 7'h19, 7'h30, 1'b0);
        for (int p = 0; p < 32; p++) begin
            tick(exp_at(p, 7'h40, 7'h79, 7'h19, 7'h30, (p <= 9) ? dk : 1'b0));
            if (p == 9) blink = 1'b0;
        end
        for (int p = 0; p < 14; p++) tick(exp_at(p, 7'h40, 7'h79, 7'h19, 7'h30, 1'b0));

        // Asynchronous reset in the middle of a DRIVE slot.
        cur_test = "t4";
        @(negedge clk);
        #2;
        chk("pre_rst_an", int'(an), 'hB);
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", int'(an), 'hF);
        chk("async_rst_seg", int'(seg), 'h7F);
        chk("async_rst_fs", int'(frame_start), 0);
        #20;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
